serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder. It latches two WIDTH-bit operands and a carry-in, then feeds one bit pair per clock, LSB first, through a single `full_adder` instance. It registers the carry between cycles and shifts each SUM bit into a result register. It sits directly upstream of the existing one-bit `full_adder`, driving its A/B/Cin and consuming its SUM/CARRY. This trades area for latency on multi-bit additions.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 1.

Ports:
- Clock and reset: one clock `CLK`; reset `RST` is synchronous and active-high.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous active-high reset.
- START  input  1  request a new addition; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; latched on an accepted START.
- B  input  WIDTH  operand B; latched on an accepted START.
- Cin  input  1  carry-in; latched on an accepted START.
- SUB  input  1  subtract select. Present only with `SERIAL_ADDER_SUB_EN`.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse when SUM/CARRY become final.
- SUM  output  WIDTH  result register.
- CARRY  output  1  final carry-out (MSB carry).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE --START--> RUN.
  - RUN --(bit count == WIDTH-1)--> DONE.
  - DONE --START--> RUN.
  - DONE --no START--> IDLE.
- Accepted START:
  - Loads shift registers `a_sh`/`b_sh` from A/B and the carry register from Cin.
  - Clears the bit counter and clears SUM.
- Each RUN cycle:
  - `full_adder` inputs are `a_sh[0]`, `b_sh[0]` and the carry register.
  - On the edge, SUM shifts right with the adder SUM entering at the MSB.
  - `a_sh`/`b_sh` shift right; the carry register takes the adder CARRY; the counter increments.
- After WIDTH RUN cycles: SUM[WIDTH-1:0] equals (A+B+Cin) mod 2^WIDTH, and CARRY equals bit WIDTH of A+B+Cin.
- CARRY output mirrors the carry register in DONE, IDLE and RUN. It is only meaningful while DONE=1 or afterwards.
- SUM and CARRY hold their values in IDLE until the next accepted START.
- START is ignored while in RUN, and the operands are not re-sampled.
- Reset values: state IDLE, SUM=0, CARRY=0, BUSY=0, DONE=0, counter 0.
- Reset mid-operation aborts immediately with no DONE pulse. The partial result is discarded and SUM reads 0.
- WIDTH=1: a single RUN cycle.

## Timing
- START sampled high at edge N (state IDLE/DONE). RUN occupies the cycles after edges N through N+WIDTH-1.
- BUSY is high for exactly WIDTH cycles.
- Final bit is written at edge N+WIDTH. DONE=1 for the single cycle following edge N+WIDTH, with SUM/CARRY final in that cycle.
- Latency: WIDTH+1 edges from START sample to DONE visible.
- Back-to-back: START high during the DONE cycle is accepted. RUN resumes next cycle, giving a throughput of one result per WIDTH+1 cycles.
- RST and START in the same cycle: RST wins.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_ADDER_SUB_EN` defined:
  - The SUB port exists.
  - On an accepted START with SUB=1, B is latched inverted and the carry register is loaded with 1 (Cin ignored), so SUM = (A−B) mod 2^WIDTH.
  - CARRY=1 means no borrow.
  - With SUB=0, the operation is an add as usual.
- Undefined: no SUB port; add only; no inversion logic.

## Structure
- Package `serial_adder_pkg`:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Counter-width helper, CNT_W = $clog2(WIDTH) with a minimum of 1.
- Sub-module: exactly one instance of the existing `full_adder` (ports A, B, Cin, SUM, CARRY). No other arithmetic is inferred in the datapath.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, Cin=0, pulse START → BUSY high 8 cycles; DONE pulses 9 edges after START; SUM=0x96, CARRY=0.
- A=0xFF, B=0x01, Cin=0 → SUM=0x00, CARRY=1. Then A=0xFF, B=0x00, Cin=1 → SUM=0x00, CARRY=1.
- RST asserted 3 cycles into RUN → next cycle shows BUSY=0, DONE=0, SUM=0, CARRY=0, no DONE pulse. A fresh START then yields the correct result.
- START re-pulsed with A=0x01 while BUSY → ignored; the first operation's result (e.g. 0x10+0x20 → 0x30) completes unchanged.
- START held high through DONE with A=0x03, B=0x04 → second result SUM=0x07 with DONE exactly 9 cycles after the first DONE.
- `SERIAL_ADDER_SUB_EN`, SUB=1, A=0x10, B=0x01 → SUM=0x0F, CARRY=1. Then A=0x00, B=0x01 → SUM=0xFF, CARRY=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helper for the bit-serial adder.
package serial_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // A one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder consumed once per cycle by serial_adder.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic SUM,
  output logic CARRY
);

  assign SUM   = A ^ B ^ Cin;
  assign CARRY = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per clock through a single full_adder, LSB first.
// Define SERIAL_ADDER_SUB_EN to add the SUB port and two's-complement subtraction.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             SUB,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  logic             accept;
  logic [WIDTH-1:0] b_load;
  logic             cin_load;
  logic             fa_sum;
  logic             fa_carry;

  assign accept = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Subtraction is A + ~B + 1, so the carry-in is forced high.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = SUB ? ~B : B;
  assign cin_load = SUB ? 1'b1 : Cin;
`else
  assign b_load   = B;
  assign cin_load = Cin;
`endif

  full_adder u_full_adder (
    .A     (a_sh_q[0]),
    .B     (b_sh_q[0]),
    .Cin   (carry_q),
    .SUM   (fa_sum),
    .CARRY (fa_carry)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE: state_d = START ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Each sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (accept) begin
      cnt_d   = '0;
      a_sh_d  = A;
      b_sh_d  = b_load;
      sum_d   = '0;
      carry_d = cin_load;
    end else if (state_q == ST_RUN) begin
      cnt_d            = cnt_q + CNT_W'(1);
      a_sh_d           = a_sh_q >> 1;
      b_sh_d           = b_sh_q >> 1;
      sum_d            = sum_q >> 1;
      sum_d[WIDTH-1]   = fa_sum;
      carry_d          = fa_carry;
    end
  end

  always_comb begin
    BUSY  = (state_q == ST_RUN);
    DONE  = (state_q == ST_DONE);
    SUM   = sum_q;
    CARRY = carry_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus random operands vs an arithmetic model.
module tb_serial_adder;

   localparam int W = 8;

   logic         CLK;
   logic         RST;
   logic         START;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         SUB;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] SUM;
   logic         CARRY;

   int checks;
   int passed;

   serial_adder #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
`ifdef SERIAL_ADDER_SUB_EN
      .SUB   (SUB),
`endif
      .BUSY  (BUSY),
      .DONE  (DONE),
      .SUM   (SUM),
      .CARRY (CARRY)
   );

   // Free-running clock, 10 time units per period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Whole-number arithmetic reference: {carry, sum}; subtraction reports "no borrow" as carry.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin, input logic sub);
      longint unsigned total;
      logic [W:0] r;
      if (sub) begin
         r[W-1:0] = W'(longint'(a) - longint'(b));
         r[W]     = (a >= b);
      end else begin
         total = longint'(a) + longint'(b) + longint'(cin);
         r     = (W+1)'(total);
      end
      return r;
   endfunction

   // Single comparison point: counts the check and reports on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks = checks + 1;
      assert (observed === expected) passed = passed + 1;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Present an operation and raise START for the next edge.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub);
      A     = a;
      B     = b;
      Cin   = cin;
      SUB   = sub;
      START = 1'b1;
   endtask

   // Waits for the accepting edge, then walks WIDTH RUN cycles and checks the DONE cycle.
   task automatic runAndCheck(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                              input logic sub, input bit holdStart, input int pokeAt, input string tag);
      logic [W:0] expected;
      int busyCnt;
      int earlyDone;
      expected  = model(a, b, cin, sub);
      busyCnt   = 0;
      earlyDone = 0;
      @(posedge CLK); #1;
      if (!holdStart) START = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (pokeAt >= 0 && i == pokeAt) begin
            A     = 8'h01;
            START = 1'b1;
         end else if (pokeAt >= 0 && i == pokeAt + 1) begin
            START = 1'b0;
         end
         if (BUSY) busyCnt++;
         if (DONE) earlyDone++;
         @(posedge CLK); #1;
      end
      checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'(W));
      checkOutput({tag, ".earlyDone"}, 32'(earlyDone), 32'd0);
      checkOutput({tag, ".done"}, 32'(DONE), 32'd1);
      checkOutput({tag, ".busyInDone"}, 32'(BUSY), 32'd0);
      checkOutput({tag, ".sum"}, 32'(SUM), 32'(expected[W-1:0]));
      checkOutput({tag, ".carry"}, 32'(CARRY), 32'(expected[W]));
   endtask

   // Watchdog so a stuck design still ends the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;
      int           doneSeen;
      checks = 0;
      passed = 0;
      RST    = 1'b1;
      START  = 1'b0;
      A      = '0;
      B      = '0;
      Cin    = 1'b0;
      SUB    = 1'b0;

      // Reset values.
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("reset.busy", 32'(BUSY), 32'd0);
      checkOutput("reset.done", 32'(DONE), 32'd0);
      checkOutput("reset.sum", 32'(SUM), 32'd0);
      checkOutput("reset.carry", 32'(CARRY), 32'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      // Basic add, then result must hold in IDLE.
      applyStimulus(8'h5A, 8'h3C, 1'b0, 1'b0);
      runAndCheck(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0, -1, "add5A3C");
      @(posedge CLK); #1;
      checkOutput("idle.donePulse", 32'(DONE), 32'd0);
      checkOutput("idle.holdSum", 32'(SUM), 32'h96);
      @(posedge CLK); #1;

      // Carry-out boundaries.
      applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
      runAndCheck(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, -1, "addFF01");
      @(posedge CLK); #1;
      applyStimulus(8'hFF, 8'h00, 1'b1, 1'b0);
      runAndCheck(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, -1, "addFF00c");
      @(posedge CLK); #1;

      // Reset three cycles into RUN aborts with no DONE pulse.
      applyStimulus(8'h12, 8'h34, 1'b1, 1'b0);
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      checkOutput("abort.busy", 32'(BUSY), 32'd0);
      checkOutput("abort.done", 32'(DONE), 32'd0);
      checkOutput("abort.sum", 32'(SUM), 32'd0);
      checkOutput("abort.carry", 32'(CARRY), 32'd0);
      doneSeen = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(posedge CLK); #1;
         if (DONE) doneSeen++;
      end
      checkOutput("abort.noDonePulse", 32'(doneSeen), 32'd0);
      applyStimulus(8'hC3, 8'h5D, 1'b0, 1'b0);
      runAndCheck(8'hC3, 8'h5D, 1'b0, 1'b0, 1'b0, -1, "afterAbort");
      @(posedge CLK); #1;

      // START re-pulsed mid-run with new A must be ignored.
      applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
      runAndCheck(8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 3, "ignoreStart");
      @(posedge CLK); #1;

      // START held high: second operation accepted in the DONE cycle.
      applyStimulus(8'h21, 8'h42, 1'b0, 1'b0);
      runAndCheck(8'h21, 8'h42, 1'b0, 1'b0, 1'b1, -1, "held1");
      A = 8'h03;
      B = 8'h04;
      runAndCheck(8'h03, 8'h04, 1'b0, 1'b0, 1'b0, -1, "held2");
      @(posedge CLK); #1;

`ifdef SERIAL_ADDER_SUB_EN
      applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
      runAndCheck(8'h10, 8'h01, 1'b0, 1'b1, 1'b0, -1, "sub1001");
      @(posedge CLK); #1;
      applyStimulus(8'h00, 8'h01, 1'b0, 1'b1);
      runAndCheck(8'h00, 8'h01, 1'b0, 1'b1, 1'b0, -1, "sub0001");
      @(posedge CLK); #1;
`endif

      // Random operands, some back-to-back from the DONE cycle.
      for (int n = 0; n < 24; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         applyStimulus(ra, rb, rc, rs);
         runAndCheck(ra, rb, rc, rs, 1'b0, -1, "random");
         if (($urandom % 2) == 0) begin
            @(posedge CLK); #1;
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
